// File: rtl/piso_shift_ctrl_pkg.sv
// Shared state encodings and counter-width helper for the PISO shift controller.
package piso_shift_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_PAR   = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Bit counter width: enough to hold WIDTH-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

  localparam int unsigned DEF_WIDTH = 4;
  localparam int unsigned CNT_W     = cnt_width(DEF_WIDTH);

endpackage

// File: rtl/piso_shift_dp.sv
// WIDTH-bit parallel-load shift register; exposes the first bit of the load word
// and the bit that becomes current after the next shift.
module piso_shift_dp #(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] load_data,
  output logic             first_bit_c,
  output logic             next_bit_c
);

  logic [WIDTH-1:0] sr_q, sr_d;

  always_comb begin
    sr_d = sr_q;
    if (load) begin
      sr_d = load_data;
    end else if (shift) begin
      sr_d = (MSB_FIRST != 0) ? {sr_q[WIDTH-2:0], 1'b0} : {1'b0, sr_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign first_bit_c = (MSB_FIRST != 0) ? load_data[WIDTH-1] : load_data[0];
  assign next_bit_c  = (MSB_FIRST != 0) ? sr_q[WIDTH-2]      : sr_q[1];

endmodule

// File: rtl/piso_shift_ctrl.sv
// Load/shift/count controller for a serial word transmitter with frame markers.
// Define PISO_SHIFT_CTRL_PARITY_EN to append an even-parity bit to each frame.
module piso_shift_ctrl
  import piso_shift_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             abort,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             frame_start,
  output logic             done
);

  localparam int unsigned CW = cnt_width(WIDTH);

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            ser_out_q, ser_out_d;
  logic            ser_valid_q, ser_valid_d;
  logic            frame_start_q, frame_start_d;
  logic            done_q, done_d;
  logic            load, shift, accept;
  logic            first_bit_c, next_bit_c;
`ifdef PISO_SHIFT_CTRL_PARITY_EN
  logic            par_q, par_d;
`endif

  assign in_ready = reset_n && (state_q == ST_IDLE) && !abort;
  assign accept   = in_valid && in_ready;

  piso_shift_dp #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_dp (
    .clk         (clk),
    .reset_n     (reset_n),
    .load        (load),
    .shift       (shift),
    .load_data   (in_data),
    .first_bit_c (first_bit_c),
    .next_bit_c  (next_bit_c)
  );

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    ser_out_d     = 1'b0;
    ser_valid_d   = 1'b0;
    frame_start_d = 1'b0;
    done_d        = 1'b0;
    load          = 1'b0;
    shift         = 1'b0;
`ifdef PISO_SHIFT_CTRL_PARITY_EN
    par_d         = par_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d       = ST_SHIFT;
          load          = 1'b1;
          cnt_d         = CW'(WIDTH - 1);
          ser_out_d     = first_bit_c;
          ser_valid_d   = 1'b1;
          frame_start_d = 1'b1;
`ifdef PISO_SHIFT_CTRL_PARITY_EN
          par_d         = ^in_data;
`endif
        end
      end
      ST_SHIFT: begin
        // Abort wins over frame completion: the word is dropped without a done pulse.
        if (abort) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
`ifdef PISO_SHIFT_CTRL_PARITY_EN
          state_d     = ST_PAR;
          ser_out_d   = par_q;
          ser_valid_d = 1'b1;
`else
          state_d     = ST_DONE;
          done_d      = 1'b1;
`endif
        end else begin
          shift       = 1'b1;
          cnt_d       = cnt_q - CW'(1);
          ser_out_d   = next_bit_c;
          ser_valid_d = 1'b1;
        end
      end
`ifdef PISO_SHIFT_CTRL_PARITY_EN
      ST_PAR: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end
      end
`endif
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      ser_out_q     <= 1'b0;
      ser_valid_q   <= 1'b0;
      frame_start_q <= 1'b0;
      done_q        <= 1'b0;
`ifdef PISO_SHIFT_CTRL_PARITY_EN
      par_q         <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      ser_out_q     <= ser_out_d;
      ser_valid_q   <= ser_valid_d;
      frame_start_q <= frame_start_d;
      done_q        <= done_d;
`ifdef PISO_SHIFT_CTRL_PARITY_EN
      par_q         <= par_d;
`endif
    end
  end

  assign ser_out     = ser_out_q;
  assign ser_valid   = ser_valid_q;
  assign frame_start = frame_start_q;
  assign done        = done_q;

endmodule

// File: tb/tb_piso_shift_ctrl.sv
// Directed and random bench driving an MSB-first and an LSB-first controller in lockstep.
module tb_piso_shift_ctrl;

  localparam int unsigned W = 4;
`ifdef PISO_SHIFT_CTRL_PARITY_EN
  localparam int unsigned NB = W + 1;
`else
  localparam int unsigned NB = W;
`endif

  logic         clk = 1'b0;
  logic         reset_n;
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         abort;
  logic         rdy_m, so_m, sv_m, fs_m, dn_m;
  logic         rdy_l, so_l, sv_l, fs_l, dn_l;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  piso_shift_ctrl #(.WIDTH(W), .MSB_FIRST(1)) u_m (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(rdy_m),
    .in_data(in_data), .abort(abort), .ser_out(so_m), .ser_valid(sv_m),
    .frame_start(fs_m), .done(dn_m)
  );

  piso_shift_ctrl #(.WIDTH(W), .MSB_FIRST(0)) u_l (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(rdy_l),
    .in_data(in_data), .abort(abort), .ser_out(so_l), .ser_valid(sv_l),
    .frame_start(fs_l), .done(dn_l)
  );

  task automatic chk(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle_quiet(input string tag, input logic exp_rdy);
    chk({tag, "_rdy_m"}, rdy_m, exp_rdy);
    chk({tag, "_rdy_l"}, rdy_l, exp_rdy);
    chk({tag, "_sv_m"},  sv_m,  1'b0);
    chk({tag, "_sv_l"},  sv_l,  1'b0);
    chk({tag, "_dn_m"},  dn_m,  1'b0);
    chk({tag, "_dn_l"},  dn_l,  1'b0);
  endtask

  // Offer w in the current IDLE cycle and check the full serial frame and done pulse.
  task automatic send_frame(input logic [W-1:0] w, input logic hold_valid);
    logic em, el;
    in_valid = 1'b1;
    in_data  = w;
    chk("accept_rdy_m", rdy_m, 1'b1);
    chk("accept_rdy_l", rdy_l, 1'b1);
    tick();
    in_valid = hold_valid;
    in_data  = ~w;
    for (int i = 0; i < int'(NB); i++) begin
      if (i < int'(W)) begin
        em = w[W-1-i];
        el = w[i];
      end else begin
        em = ^w;
        el = ^w;
      end
      chk("bit_m", so_m, em);
      chk("bit_l", so_l, el);
      chk("sv_m", sv_m, 1'b1);
      chk("sv_l", sv_l, 1'b1);
      chk("fs_m", fs_m, (i == 0));
      chk("fs_l", fs_l, (i == 0));
      chk("busy_rdy", rdy_m, 1'b0);
      chk("early_done", dn_m, 1'b0);
      tick();
    end
    chk("done_m", dn_m, 1'b1);
    chk("done_l", dn_l, 1'b1);
    chk("done_sv", sv_m, 1'b0);
    chk("done_rdy", rdy_m, 1'b0);
    tick();
    chk("post_done", dn_m, 1'b0);
    chk("idle_rdy_m", rdy_m, 1'b1);
    chk("idle_rdy_l", rdy_l, 1'b1);
  endtask

  initial begin
    logic [W-1:0] w;
    reset_n  = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    abort    = 1'b0;
    #23;
    chk("rst_so", so_m, 1'b0);
    chk("rst_fs", fs_m, 1'b0);
    reset_n = 1'b1;
    tick();
    chk_idle_quiet("rst", 1'b1);

    // Reset mid-SHIFT clears outputs without waiting for a clock edge.
    in_valid = 1'b1;
    in_data  = 4'b1011;
    tick();
    in_valid = 1'b0;
    tick();
    chk("pre_rst_sv", sv_m, 1'b1);
    reset_n = 1'b0;
    #1;
    chk("arst_so_m", so_m, 1'b0);
    chk("arst_so_l", so_l, 1'b0);
    chk("arst_sv_m", sv_m, 1'b0);
    chk("arst_sv_l", sv_l, 1'b0);
    chk("arst_fs", fs_m, 1'b0);
    chk("arst_dn", dn_m, 1'b0);
    tick();
    reset_n = 1'b1;
    tick();
    chk_idle_quiet("rel", 1'b1);

    // Basic frames in both bit orders.
    send_frame(4'b1011, 1'b0);
    send_frame(4'b0001, 1'b0);

    // Back-to-back: valid held, next word taken in first IDLE cycle.
    send_frame(4'b0110, 1'b1);
    send_frame(4'b1001, 1'b0);
    tick();
    chk_idle_quiet("b2b_end", 1'b1);

    // Abort on the second serial bit of 4'hA.
    in_valid = 1'b1;
    in_data  = 4'hA;
    tick();
    in_valid = 1'b0;
    chk("ab_b0_m", so_m, 1'b1);
    chk("ab_b0_l", so_l, 1'b0);
    tick();
    chk("ab_b1_m", so_m, 1'b0);
    chk("ab_b1_l", so_l, 1'b1);
    abort = 1'b1;
    tick();
    chk_idle_quiet("ab_after", 1'b0);
    abort = 1'b0;
    #1;
    chk("ab_idle_rdy", rdy_m, 1'b1);
    tick();
    chk_idle_quiet("ab_nodone", 1'b1);

    // Abort in IDLE only blocks acceptance.
    abort    = 1'b1;
    in_valid = 1'b1;
    in_data  = 4'hF;
    #1;
    chk("ab_idle_blk_m", rdy_m, 1'b0);
    chk("ab_idle_blk_l", rdy_l, 1'b0);
    tick();
    chk("ab_not_taken", sv_m, 1'b0);
    tick();
    in_valid = 1'b0;
    abort    = 1'b0;
    tick();
    chk_idle_quiet("ab_idle_end", 1'b1);
    send_frame(4'b0111, 1'b0);
    send_frame(4'b0000, 1'b0);

    // Random words, random back-to-back.
    for (int n = 0; n < 200; n++) begin
      w = W'($urandom_range(0, (1 << W) - 1));
      send_frame(w, 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
